// File: rtl/key_search_dispatcher_pkg.sv
// Shared types and constants for the RC4 multi-core key-search dispatcher.
// The dispatcher, the interface and the bench all import this package.
package rc4_search_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SUCCESS = 2'd2,
    ST_FAILURE = 2'd3
  } search_state_t;

  localparam logic [2:0] LED_IDLE    = 3'd0;
  localparam logic [2:0] LED_RUN     = 3'd1;
  localparam logic [2:0] LED_SUCCESS = 3'd3;
  localparam logic [2:0] LED_FAIL    = 3'd4;
  localparam int         LED_PERR_BIT = 9;

  // Index width that stays at least one bit, even when there is a single core.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_search_dispatcher_if.sv
// Bundle between the dispatcher (master) and the array of decrypt cores (slave).
// Handshake: core_start[i] is a one-cycle pulse telling core i to load its
// core_key slice; the core later answers with a one-cycle core_done[i] pulse,
// and core_success[i] is only meaningful in the same cycle as core_done[i].
interface key_search_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_W     = 24
);
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_success;

  modport master (
    output core_start,
    output core_key,
    input  core_done,
    input  core_success
  );

  modport slave (
    input  core_start,
    input  core_key,
    output core_done,
    output core_success
  );
endinterface

// File: rtl/key_search_dispatcher_picker.sv
// Priority encoder: reports the index of the lowest zero bit in mask_i.
// Fed with ~vector it also finds the lowest set bit of that vector.
module lowest_idle_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the lowest zero bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (!mask_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/key_search_dispatcher.sv
// Hands successive RC4 keys to NUM_CORES decrypt cores, latches the first key
// a core reports as valid, and flags exhaustion of the key range.
module key_search_dispatcher
  import rc4_search_pkg::*;
#(
  parameter int              NUM_CORES = 4,
  parameter int              KEY_W     = 24,
  parameter longint unsigned KEY_LIMIT = 64'd4194304,
  parameter int              LED_W     = 10,
  localparam int             IDX_W     = clog2_min1(NUM_CORES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  key_search_dispatcher_if.master core_if,
  output logic                   busy,
  output logic                   found,
  output logic [KEY_W-1:0]       found_key,
  output logic [IDX_W-1:0]       found_core,
  output logic                   total_failure,
  output logic                   protocol_err,
  output logic [LED_W-1:0]       LEDR,
  output search_state_t          dbg_state_o
);

  localparam logic [KEY_W:0] LIMIT = (KEY_W + 1)'(KEY_LIMIT);

  search_state_t                       state_q;
  logic [NUM_CORES-1:0]                busy_q;
  logic [NUM_CORES-1:0]                start_q;
  logic [NUM_CORES-1:0][KEY_W-1:0]     key_q;
  logic [KEY_W:0]                      next_key_q;
  logic                                found_q;
  logic                                fail_q;
  logic                                perr_q;
  logic [KEY_W-1:0]                    found_key_q;
  logic [IDX_W-1:0]                    found_core_q;

  logic [NUM_CORES-1:0] succ_vec;
  logic [NUM_CORES-1:0] done_vec;
  logic [NUM_CORES-1:0] illegal_vec;
  logic [NUM_CORES-1:0] dispatch_mask;
  logic                 idle_valid;
  logic [IDX_W-1:0]     idle_idx;
  logic                 succ_any;
  logic [IDX_W-1:0]     succ_idx;
  logic                 dispatch_en;

  assign done_vec    = core_if.core_done & busy_q;
  assign succ_vec    = done_vec & core_if.core_success;
  assign illegal_vec = core_if.core_done & ~busy_q;

  // Uses the pre-completion mask, so a core freed on this edge waits one more.
  lowest_idle_picker #(.N(NUM_CORES), .IDX_W(IDX_W)) u_idle_pick (
    .mask_i  (busy_q),
    .valid_o (idle_valid),
    .idx_o   (idle_idx)
  );

  lowest_idle_picker #(.N(NUM_CORES), .IDX_W(IDX_W)) u_succ_pick (
    .mask_i  (~succ_vec),
    .valid_o (succ_any),
    .idx_o   (succ_idx)
  );

  assign dispatch_en   = idle_valid && (next_key_q < LIMIT);
  assign dispatch_mask = dispatch_en ? (NUM_CORES'(1) << idle_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      start_q      <= '0;
      key_q        <= '0;
      next_key_q   <= '0;
      found_q      <= 1'b0;
      fail_q       <= 1'b0;
      perr_q       <= 1'b0;
      found_key_q  <= '0;
      found_core_q <= '0;
    end else begin
      start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            next_key_q <= '0;
            busy_q     <= '0;
          end
        end
        ST_RUN: begin
          if (|illegal_vec) perr_q <= 1'b1;
          // Success is checked first so it beats a simultaneous exhaustion.
          if (succ_any) begin
            state_q      <= ST_SUCCESS;
            found_q      <= 1'b1;
            found_key_q  <= key_q[succ_idx];
            found_core_q <= succ_idx;
            busy_q       <= busy_q & ~done_vec;
          end else if ((next_key_q == LIMIT) && (busy_q == '0)) begin
            state_q <= ST_FAILURE;
            fail_q  <= 1'b1;
          end else begin
            busy_q <= (busy_q & ~done_vec) | dispatch_mask;
            if (dispatch_en) begin
              start_q[idle_idx] <= 1'b1;
              key_q[idle_idx]   <= next_key_q[KEY_W-1:0];
              next_key_q        <= next_key_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_if.core_start = start_q;
  assign core_if.core_key   = key_q;
  assign busy               = (state_q == ST_RUN);
  assign found              = found_q;
  assign found_key          = found_key_q;
  assign found_core         = found_core_q;
  assign total_failure      = fail_q;
  assign protocol_err       = perr_q;
  assign dbg_state_o        = state_q;

  always_comb begin
    LEDR = '0;
    case (state_q)
      ST_IDLE:    LEDR[2:0] = LED_IDLE;
      ST_RUN:     LEDR[2:0] = LED_RUN;
      ST_SUCCESS: LEDR[2:0] = LED_SUCCESS;
      default:    LEDR[2:0] = LED_FAIL;
    endcase
    LEDR[LED_PERR_BIT] = perr_q;
  end

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Directed bench for key_search_dispatcher: a scoreboard queue of expected
// (core, key) dispatches checked by a monitor, plus status checks per scenario.
module tb_key_search_dispatcher;
  import rc4_search_pkg::*;

  localparam int NC = 4;
  localparam int KW = 24;
  localparam int KL = 16;
  localparam int LW = 10;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          found;
  logic [KW-1:0] found_key;
  logic [IW-1:0] found_core;
  logic          total_failure;
  logic          protocol_err;
  logic [LW-1:0] LEDR;
  search_state_t dbg_state;

  logic [NC-1:0] auto_done, auto_succ, man_done, man_succ;

  key_search_dispatcher_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();
  assign bus.core_done    = auto_done | man_done;
  assign bus.core_success = auto_succ | man_succ;

  key_search_dispatcher #(
    .NUM_CORES (NC),
    .KEY_W     (KW),
    .KEY_LIMIT (64'(KL)),
    .LED_W     (LW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .core_if       (bus),
    .busy          (busy),
    .found         (found),
    .found_key     (found_key),
    .found_core    (found_core),
    .total_failure (total_failure),
    .protocol_err  (protocol_err),
    .LEDR          (LEDR),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- core responder ----------------
  // Answers core_done three cycles after a core_start; success when key matches.
  bit          auto_en  = 1'b0;
  int          succ_key = -1;
  int          cnt[NC];
  logic [KW-1:0] rkey[NC];

  initial begin
    auto_done = '0;
    auto_succ = '0;
    for (int i = 0; i < NC; i++) begin
      cnt[i]  = 0;
      rkey[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        auto_done[i] = 1'b0;
        auto_succ[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            auto_done[i] = 1'b1;
            auto_succ[i] = (int'(rkey[i]) == succ_key);
          end
        end
        if (auto_en && bus.core_start[i]) begin
          cnt[i]  = 2;
          rkey[i] = bus.core_key[i*KW +: KW];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && (bus.core_start != '0)) begin
        chk("one_start_per_edge", 64'($countones(bus.core_start) == 1), 64'(1));
        for (int i = 0; i < NC; i++) begin
          if (bus.core_start[i]) begin
            got = {8'(i), bus.core_key[i*KW +: KW]};
            chk("dispatch_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
              exp = exp_q.pop_front();
              chk("dispatch_core_key", 64'(got), 64'(exp));
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_keys(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({8'(k % NC), 24'(k)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_core_start"},    64'(bus.core_start), 64'(0));
    chk({tag, "_core_key"},      64'(bus.core_key), 64'(0));
    chk({tag, "_busy"},          64'(busy), 64'(0));
    chk({tag, "_found"},         64'(found), 64'(0));
    chk({tag, "_found_key"},     64'(found_key), 64'(0));
    chk({tag, "_found_core"},    64'(found_core), 64'(0));
    chk({tag, "_total_failure"}, 64'(total_failure), 64'(0));
    chk({tag, "_protocol_err"},  64'(protocol_err), 64'(0));
    chk({tag, "_ledr"},          64'(LEDR), 64'(0));
    chk({tag, "_state"},         64'(dbg_state), 64'(ST_IDLE));
  endtask

  // Waits for total_failure; cyc counts negedges with the start edge as 1.
  task automatic wait_failure(inout int cyc);
    while (!total_failure && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cyc;
    reset    = 1'b1;
    start    = 1'b0;
    man_done = '0;
    man_succ = '0;
    step(3);
    reset = 1'b0;
    step();
    check_idle("reset");

    // Full range with no success: keys 0..15 to cores k%4, failure 20 edges after start.
    auto_en  = 1'b1;
    succ_key = -1;
    push_keys(KL);
    pulse_start();
    cyc = 1;
    chk("run_busy",        64'(busy), 64'(1));
    chk("run_ledr",        64'(LEDR), 64'(LED_RUN));
    chk("run_first_quiet", 64'(bus.core_start), 64'(0));
    step();
    cyc++;
    chk("run_first_start", 64'(bus.core_start), 64'(4'b0001));
    wait_failure(cyc);
    chk("fail_cycle",      64'(cyc), 64'(21));
    chk("fail_flag",       64'(total_failure), 64'(1));
    chk("fail_ledr",       64'(LEDR), 64'(LED_FAIL));
    chk("fail_found",      64'(found), 64'(0));
    chk("fail_busy",       64'(busy), 64'(0));
    chk("fail_all_keys",   64'(exp_q.size()), 64'(0));

    // Key 5 succeeds on core 1; dispatch stops after key 7.
    do_reset();
    succ_key = 5;
    push_keys(8);
    pulse_start();
    cyc = 1;
    while (!found && cyc < 100) begin
      step();
      cyc++;
    end
    chk("succ_cycle",      64'(cyc), 64'(10));
    chk("succ_found",      64'(found), 64'(1));
    chk("succ_key",        64'(found_key), 64'(5));
    chk("succ_core",       64'(found_core), 64'(1));
    chk("succ_ledr",       64'(LEDR), 64'(LED_SUCCESS));
    chk("succ_state",      64'(dbg_state), 64'(ST_SUCCESS));
    step(10);
    chk("succ_no_more",    64'(exp_q.size()), 64'(0));
    chk("succ_late_done",  64'(protocol_err), 64'(0));
    chk("succ_no_fail",    64'(total_failure), 64'(0));
    chk("succ_held_key",   64'(found_key), 64'(5));

    // Cores 1 and 2 report success together: lowest index wins.
    do_reset();
    auto_en  = 1'b0;
    succ_key = -1;
    push_keys(4);
    pulse_start();
    step(5);
    man_done = 4'b0110;
    man_succ = 4'b0110;
    step();
    man_done = '0;
    man_succ = '0;
    chk("tie_found",       64'(found), 64'(1));
    chk("tie_core",        64'(found_core), 64'(1));
    chk("tie_key",         64'(found_key), 64'(1));
    chk("tie_ledr",        64'(LEDR), 64'(LED_SUCCESS));
    step(3);
    chk("tie_dispatches",  64'(exp_q.size()), 64'(0));

    // Reset mid-run; in-flight completions then land in IDLE.
    do_reset();
    auto_en = 1'b1;
    push_keys(KL);
    pulse_start();
    step(5);
    reset = 1'b1;
    step();
    exp_q.delete();
    reset = 1'b0;
    step(8);
    check_idle("midrst");

    // Fresh start from key 0, stray done on idle core 3, start pulsed during RUN.
    push_keys(KL);
    pulse_start();
    cyc = 1;
    man_done = 4'b1000;
    step();
    cyc++;
    man_done = '0;
    start    = 1'b1;
    step();
    cyc++;
    start = 1'b0;
    chk("perr_flag",       64'(protocol_err), 64'(1));
    chk("perr_ledr",       64'(LEDR), 64'(10'h201));
    wait_failure(cyc);
    chk("perr_fail_cycle", 64'(cyc), 64'(21));
    chk("perr_fail_ledr",  64'(LEDR), 64'(10'h204));
    chk("perr_all_keys",   64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
